// File: rtl/k10_uart_tx.sv
// AXI4-Lite transmit-only UART: TX FIFO drained as 8N1 frames, LSB first, on o_tx.
// Define K10_UART_TX_SIM_PRINT_EN to echo every accepted TXDATA byte to the simulator console.
//
// state  | meaning
// S_IDLE | line high, waiting for tx_en and a queued byte
// S_START| start bit (low) for DIV cycles
// S_DATA | data bits 0..7 from shift[0], DIV cycles each
// S_STOP | stop bit (high) for DIV cycles, may chain straight into the next frame
module k10_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state, state_nx;
  logic [15:0] baud_cnt, baud_cnt_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_bit, pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push;

  logic [15:0] div_q, div_eff;
  logic [1:0]  ctrl_q;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_word;
  logic        wr_hs, ar_hs, rd_err;
  logic        wr_txdata, wr_status, wr_div, wr_ctrl, wr_err;
  logic [11:0] wr_off, rd_off;
  logic [8:0]  lvl9;
  logic        unused_bits;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign lvl9    = 9'(count);

  // Register interface: AW and W are taken together only while no B is outstanding.
  assign wr_hs     = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !i_rst;
  assign wr_off    = s_axi_awaddr[11:0];
  assign wr_txdata = (wr_off == 12'h000);
  assign wr_status = (wr_off == 12'h004);
  assign wr_div    = (wr_off == 12'h008);
  assign wr_ctrl   = (wr_off == 12'h00C);
  assign wr_err    = !(wr_txdata || wr_status || wr_div || wr_ctrl)
                     || (wr_txdata && s_axi_wstrb[0] && full);
  assign push      = wr_hs && wr_txdata && s_axi_wstrb[0] && !full;

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = !rvalid_q && !i_rst;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  assign rd_off        = s_axi_araddr[11:0];
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_off)
      12'h000: rd_word = '0;
      12'h004: begin
        rd_word[0]    = full;
        rd_word[1]    = empty;
        rd_word[2]    = (state != S_IDLE);
        rd_word[15:8] = lvl9[7:0];
      end
      12'h008: rd_word[15:0] = div_q;
      12'h00C: rd_word[1:0]  = ctrl_q;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      div_q    <= DEFAULT_DIV;
      ctrl_q   <= 2'b00;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
        if (wr_div && s_axi_wstrb[0]) div_q[7:0]  <= s_axi_wdata[7:0];
        if (wr_div && s_axi_wstrb[1]) div_q[15:8] <= s_axi_wdata[15:8];
        if (wr_ctrl && s_axi_wstrb[0]) ctrl_q <= s_axi_wdata[1:0];
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_err ? 2'b10 : 2'b00;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // FIFO: fullness is judged before the edge, so a same-cycle pop never frees a slot for a push.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= s_axi_wdata[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift;
    pop         = 1'b0;
    tx_bit      = 1'b1;
    case (state)
      S_IDLE: begin
        if (ctrl_q[0] && !empty) begin
          pop         = 1'b1;
          shift_nx    = mem[rd_ptr];
          baud_cnt_nx = div_eff - 16'd1;
          state_nx    = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (baud_cnt == 16'd0) begin
          baud_cnt_nx = div_eff - 16'd1;
          bit_idx_nx  = 3'd0;
          state_nx    = S_DATA;
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        tx_bit = shift[0];
        if (baud_cnt == 16'd0) begin
          baud_cnt_nx = div_eff - 16'd1;
          shift_nx    = shift >> 1;
          bit_idx_nx  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt == 16'd0) begin
          // chain the next frame directly so there is no idle gap between frames
          if (ctrl_q[0] && !empty) begin
            pop         = 1'b1;
            shift_nx    = mem[rd_ptr];
            baud_cnt_nx = div_eff - 16'd1;
            state_nx    = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          baud_cnt_nx = baud_cnt - 16'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_tx     <= 1'b1;
      o_irq    <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shift    <= shift_nx;
      o_tx     <= tx_bit;
      o_irq    <= ctrl_q[1] && empty && (state == S_IDLE);
    end
  end

`ifdef K10_UART_TX_SIM_PRINT_EN
  always_ff @(posedge i_clk) begin
    if (push) $write("%c", s_axi_wdata[7:0]);
  end
`else
  // synthesizable build: no console echo
`endif

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:12], s_axi_araddr[31:12],
                         s_axi_wdata[31:16], s_axi_wstrb[3:2], lvl9[8]};

endmodule
